dst_sequencer: RTL and testbench
================================

// Module: dst_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 4-entry, 2-bit-addressed register-file write path.
//  - Fetches 8-bit instructions over a valid/ready handshake and decodes them.
//  - Sequences an optional memory access.
//  - Drives the destination-select mux (dst_type/dst_d) and rf_we for exactly one WB cycle per instruction.
//  - Sits between instruction source, data memory port and RF write-destination mux.
// PARAMETERS
//  PC_W        8   width of program counter pc
//  MEM_TMO     15  max cycles waiting for mem_ack before fault (1..2^TMO_W-1)
//  TMO_W       4   width of timeout counter
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous reset, active-high
//  instr_valid  in   1     instr holds a valid instruction
//  instr_ready  out  1     sequencer accepts instr this cycle
//  instr        in   8     {op[7:6], rs[5:4], rt[3:2], d[1:0]}
//  pc           out  PC_W  address of next instruction to fetch
//  rf_raddr1    out  2     RF read port 1 address (= rs)
//  rf_raddr2    out  2     RF read port 2 address (= rt)
//  mem_req      out  1     data memory request, held until mem_ack
//  mem_ack      in   1     data memory done (1-cycle pulse)
//  dst_type     out  2     dest select: 00=rs field, 01=computed, 10=d field
//  dst_d        out  2     immediate destination (= d), valid with dst_type=10
//  rf_we        out  1     RF write enable, single-cycle pulse in WB
//  halted       out  1     sticky: HALT executed or memory fault
//  fault        out  1     sticky: mem_ack timeout
// BEHAVIOUR
//  Reset (async, any state): state=FETCH, pc=0, all outputs 0, latched instr=0, tmo counter=0.
//  States: FETCH -> DECODE -> {EXEC | MEM} -> WB -> FETCH; HALT is terminal.
//  FETCH
//   - instr_ready=1.
//   - On instr_valid&instr_ready: latch instr, pc<=pc+1 (wraps mod 2^PC_W), go DECODE.
//   - No handshake: stay, pc unchanged.
//  DECODE
//   - rf_raddr1/2 driven from latched rs/rt from this state until WB exit.
//   - op=00 (ALU) -> EXEC; op=01 (LOAD) -> MEM; op=10 (LI) -> WB.
//   - op=11 with d!=00 -> WB; op=11 with d==00 (HALT) -> HALT.
//  EXEC: one cycle, -> WB.
//  MEM
//   - mem_req=1, tmo counter increments each cycle.
//   - mem_ack -> mem_req=0 next cycle, counter cleared, go WB.
//   - counter==MEM_TMO without ack -> fault=1, halted=1, go HALT, no RF write.
//   - mem_ack in the same cycle as timeout wins: go WB, no fault.
//  WB
//   - rf_we=1 for exactly this cycle; dst_type by op: 00->01, 01->00, 10->10.
//   - op=11, d!=00 -> rf_we=0 (NOP), dst_type=00.
//   - dst_d = d; next state FETCH.
//  HALT
//   - instr_ready=0, mem_req=0, rf_we=0, halted=1.
//   - Leaves only via rst.
//  General rules
//   - dst_type never 11.
//   - Outside WB, dst_type and dst_d hold their last value and rf_we=0.
//   - All outputs registered, no combinational path input->output.
//  Latency (accept -> rf_we):
//   - ALU: 3 cycles.
//   - LI: 2 cycles.
//   - LOAD: 3 + ack wait cycles.
//  mem_ack outside MEM is ignored. instr_valid outside FETCH is ignored (not consumed).
//  rst asserted mid-MEM drops mem_req immediately; the pending ack is ignored after release.
// TESTING
//  1. Reset, feed 8'b10_00_00_11 (LI d=3): rf_we 2 cycles after accept, dst_type=10, dst_d=3, pc=1.
//  2. ALU 8'b00_01_10_00: DECODE shows raddr1=1, raddr2=2; WB 3 cycles after accept with dst_type=01.
//  3. LOAD, mem_ack after 4 cycles of mem_req: dst_type=00 WB the next cycle; no fault.
//  4. LOAD, no ack: fault=halted=1 after MEM_TMO cycles; rf_we never pulses; instr_ready stays 0.
//  5. HALT 8'hC0 then rst pulse mid-stream: halted=1, then all outputs 0, pc=0, FETCH resumes.
//  6. pc at 2^PC_W-1, accept instr: pc wraps to 0. instr_valid held low 5 cycles: no state change.

Source files
------------

// File: rtl/dst_sequencer.sv
// Control sequencer for the 4-entry register-file write path: fetch, decode,
// optional memory access, then a single write-back cycle per instruction.
module dst_sequencer #(
   parameter int PC_W    = 8,
   parameter int MEM_TMO = 15,
   parameter int TMO_W   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [7:0]      instr,
   output logic [PC_W-1:0] pc,
   output logic [1:0]      rf_raddr1,
   output logic [1:0]      rf_raddr2,
   output logic            mem_req,
   input  logic            mem_ack,
   output logic [1:0]      dst_type,
   output logic [1:0]      dst_d,
   output logic            rf_we,
   output logic            halted,
   output logic            fault
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [1:0] OP_ALU  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_LI   = 2'b10;

   logic [2:0]       state;
   logic [2:0]       nxt;
   logic [7:0]       ir;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_inc;
   logic             accept;
   logic             timeout;
   logic [1:0]       op;
   logic [1:0]       wb_type;

   assign op = ir[7:6];

   // Outputs are registered from the next state, so every decision is made here
   // and becomes visible in the cycle the FSM actually occupies that state.
   always_comb begin
      accept  = (state == S_FETCH) && instr_ready && instr_valid;
      tmo_inc = tmo_cnt + 1'b1;
      timeout = (tmo_inc == TMO_W'(MEM_TMO));
      nxt     = state;
      case (state)
         S_FETCH:  if (accept) nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_ALU:  nxt = S_EXEC;
               OP_LOAD: nxt = S_MEM;
               OP_LI:   nxt = S_WB;
               default: nxt = (ir[1:0] == 2'b00) ? S_HALT : S_WB;
            endcase
         end
         S_EXEC:   nxt = S_WB;
         S_MEM: begin
            if (mem_ack)      nxt = S_WB;
            else if (timeout) nxt = S_HALT;
         end
         S_WB:     nxt = S_FETCH;
         S_HALT:   nxt = S_HALT;
         default:  nxt = S_FETCH;
      endcase
   end

   // Destination mux encoding; the NOP form of op=11 selects the rs field.
   always_comb begin
      case (op)
         OP_ALU:  wb_type = 2'b01;
         OP_LOAD: wb_type = 2'b00;
         OP_LI:   wb_type = 2'b10;
         default: wb_type = 2'b00;
      endcase
   end

   // State, fetch bookkeeping and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         pc          <= '0;
         ir          <= '0;
         tmo_cnt     <= '0;
         instr_ready <= 1'b0;
         rf_raddr1   <= 2'b00;
         rf_raddr2   <= 2'b00;
         mem_req     <= 1'b0;
         dst_type    <= 2'b00;
         dst_d       <= 2'b00;
         rf_we       <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= nxt;
         instr_ready <= (nxt == S_FETCH);
         mem_req     <= (nxt == S_MEM);
         rf_we       <= (nxt == S_WB) && (op != 2'b11);
         if (accept) begin
            ir        <= instr;
            pc        <= pc + 1'b1;
            rf_raddr1 <= instr[5:4];
            rf_raddr2 <= instr[3:2];
         end
         if ((state == S_MEM) && (nxt == S_MEM)) tmo_cnt <= tmo_inc;
         else                                     tmo_cnt <= '0;
         if (nxt == S_WB) begin
            dst_type <= wb_type;
            dst_d    <= ir[1:0];
         end
         if (nxt == S_HALT) halted <= 1'b1;
         if ((state == S_MEM) && (nxt == S_HALT)) fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dst_sequencer.sv
// Directed self-checking bench for dst_sequencer; inputs change and outputs are
// sampled on the falling clock edge.
module tb_dst_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [7:0] instr = 8'h00;
   logic [7:0] pc;
   logic [1:0] rf_raddr1;
   logic [1:0] rf_raddr2;
   logic       mem_req;
   logic       mem_ack = 1'b0;
   logic [1:0] dst_type;
   logic [1:0] dst_d;
   logic       rf_we;
   logic       halted;
   logic       fault;

   int passCount  = 0;
   int checkCount = 0;

   dst_sequencer #(.PC_W(8), .MEM_TMO(15), .TMO_W(4)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .pc(pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .mem_req(mem_req), .mem_ack(mem_ack), .dst_type(dst_type), .dst_d(dst_d),
      .rf_we(rf_we), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offers one instruction and returns at the falling edge after the accept edge.
   task automatic feed(input logic [7:0] v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (instr_ready) begin
            instr = v; instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkCount++; if ({instr_ready, mem_req, rf_we, halted, fault} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {instr_ready, mem_req, rf_we, halted, fault}); else passCount++;
      checkCount++; if ({pc, rf_raddr1, rf_raddr2, dst_type, dst_d} !== 16'h0) $display("FAIL reset_data: got %h expected 0000", {pc, rf_raddr1, rf_raddr2, dst_type, dst_d}); else passCount++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkCount++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", instr_ready); else passCount++;
   endtask

   task automatic test_li();
      bit ok;
      applyReset();
      feed(8'b10_00_00_11, ok);
      checkCount++; if (!ok) $display("FAIL li_accept: got no handshake expected accept"); else passCount++;
      checkCount++; if (pc !== 8'd1 || rf_we !== 1'b0) $display("FAIL li_decode: got pc=%0d we=%b expected pc=1 we=0", pc, rf_we); else passCount++;
      @(negedge clk);
      checkCount++; if ({rf_we, dst_type, dst_d} !== 5'b1_10_11) $display("FAIL li_wb: got %b expected 11011", {rf_we, dst_type, dst_d}); else passCount++;
      @(negedge clk);
      checkCount++; if ({rf_we, dst_type, dst_d, instr_ready} !== 6'b0_10_11_1) $display("FAIL li_hold: got %b expected 010111", {rf_we, dst_type, dst_d, instr_ready}); else passCount++;
   endtask

   task automatic test_alu();
      bit ok;
      applyReset();
      feed(8'b00_01_10_00, ok);
      checkCount++; if (!ok) $display("FAIL alu_accept: got no handshake expected accept"); else passCount++;
      checkCount++; if ({rf_raddr1, rf_raddr2, rf_we} !== 5'b01_10_0) $display("FAIL alu_raddr: got %b expected 01100", {rf_raddr1, rf_raddr2, rf_we}); else passCount++;
      instr = 8'hFF; instr_valid = 1'b1;
      @(negedge clk);
      checkCount++; if (rf_we !== 1'b0) $display("FAIL alu_exec_we: got %b expected 0", rf_we); else passCount++;
      @(negedge clk);
      instr_valid = 1'b0;
      checkCount++; if ({rf_we, dst_type, dst_d} !== 5'b1_01_00) $display("FAIL alu_wb: got %b expected 10100", {rf_we, dst_type, dst_d}); else passCount++;
      checkCount++; if (pc !== 8'd1 || rf_raddr1 !== 2'd1) $display("FAIL alu_valid_ignored: got pc=%0d raddr1=%0d expected pc=1 raddr1=1", pc, rf_raddr1); else passCount++;
   endtask

   task automatic test_load();
      bit ok;
      applyReset();
      feed(8'b01_11_00_01, ok);
      checkCount++; if (!ok || mem_req !== 1'b0) $display("FAIL load_decode: got ok=%b req=%b expected ok=1 req=0", ok, mem_req); else passCount++;
      for (int i = 0; i < 3; i++) @(negedge clk);
      @(negedge clk);
      checkCount++; if (mem_req !== 1'b1 || rf_we !== 1'b0) $display("FAIL load_req: got req=%b we=%b expected req=1 we=0", mem_req, rf_we); else passCount++;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checkCount++; if ({mem_req, rf_we, dst_type, dst_d, fault} !== 7'b0_1_00_01_0) $display("FAIL load_wb: got %b expected 0100010", {mem_req, rf_we, dst_type, dst_d, fault}); else passCount++;
   endtask

   task automatic test_timeout();
      bit ok;
      int weSeen = 0;
      int reqCycles = 0;
      applyReset();
      feed(8'h40, ok);
      checkCount++; if (!ok) $display("FAIL tmo_accept: got no handshake expected accept"); else passCount++;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (mem_req) reqCycles++;
         if (rf_we) weSeen++;
      end
      checkCount++; if (reqCycles !== 15 || fault !== 1'b0) $display("FAIL tmo_wait: got req_cycles=%0d fault=%b expected 15 and 0", reqCycles, fault); else passCount++;
      @(negedge clk);
      checkCount++; if ({fault, halted, mem_req, instr_ready} !== 4'b1100) $display("FAIL tmo_fault: got %b expected 1100", {fault, halted, mem_req, instr_ready}); else passCount++;
      instr = 8'h80; instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rf_we || instr_ready) weSeen++;
      end
      instr_valid = 1'b0;
      checkCount++; if (weSeen !== 0 || pc !== 8'd1) $display("FAIL tmo_stuck: got activity=%0d pc=%0d expected 0 and 1", weSeen, pc); else passCount++;
   endtask

   task automatic test_halt_reset();
      bit ok;
      applyReset();
      feed(8'hC0, ok);
      @(negedge clk);
      checkCount++; if ({halted, fault, instr_ready, rf_we} !== 4'b1000) $display("FAIL halt_state: got %b expected 1000", {halted, fault, instr_ready, rf_we}); else passCount++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkCount++; if ({pc, halted, fault, instr_ready, mem_req, rf_we} !== 13'h0) $display("FAIL halt_rst: got %h expected 0000", {pc, halted, fault, instr_ready, mem_req, rf_we}); else passCount++;
      @(negedge clk);
      rst = 1'b0;
      feed(8'b10_00_00_10, ok);
      checkCount++; if (!ok || pc !== 8'd1) $display("FAIL halt_resume: got ok=%b pc=%0d expected 1 and 1", ok, pc); else passCount++;
      @(negedge clk);
      checkCount++; if ({rf_we, dst_type, dst_d} !== 5'b1_10_10) $display("FAIL halt_resume_wb: got %b expected 11010", {rf_we, dst_type, dst_d}); else passCount++;
   endtask

   task automatic test_reset_mid_mem();
      bit ok;
      int weSeen = 0;
      applyReset();
      feed(8'h41, ok);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkCount++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", mem_req); else passCount++;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rf_we || mem_req) weSeen++;
      end
      checkCount++; if (weSeen !== 0 || instr_ready !== 1'b1) $display("FAIL rst_mem_ack: got activity=%0d ready=%b expected 0 and 1", weSeen, instr_ready); else passCount++;
   endtask

   task automatic test_pc_wrap_idle();
      bit ok;
      bit allOk = 1'b1;
      int idleBad = 0;
      applyReset();
      feed(8'hC1, ok);
      @(negedge clk);
      checkCount++; if ({rf_we, dst_type, dst_d} !== 5'b0_00_01) $display("FAIL nop_wb: got %b expected 00001", {rf_we, dst_type, dst_d}); else passCount++;
      for (int i = 1; i < 255; i++) begin
         feed(8'hC1, ok);
         allOk &= ok;
      end
      checkCount++; if (!allOk || pc !== 8'd255) $display("FAIL pc_top: got ok=%b pc=%0d expected 1 and 255", allOk, pc); else passCount++;
      feed(8'hC2, ok);
      checkCount++; if (!ok || pc !== 8'd0) $display("FAIL pc_wrap: got ok=%b pc=%0d expected 1 and 0", ok, pc); else passCount++;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (pc !== 8'd0 || instr_ready !== 1'b1 || rf_we !== 1'b0) idleBad++;
      end
      checkCount++; if (idleBad !== 0) $display("FAIL idle_hold: got %0d bad cycles expected 0", idleBad); else passCount++;
   endtask

   initial begin
      test_reset();
      test_li();
      test_alu();
      test_load();
      test_timeout();
      test_halt_reset();
      test_reset_mid_mem();
      test_pc_wrap_idle();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
